dmem_access_ctrl: RTL and testbench

Sequences every data-memory access of the RV32IM MEM stage against a variable-latency data memory with a request/ready handshake. Stalls the upstream pipeline while an access is outstanding and produces sign/zero-extended load data plus a MEM/WB capture enable. Sits between the EX/MEM pipeline register outputs and the MEM/WB pipeline register; the memory array is external.

---
 rtl/rv_mem_pkg.sv | 67 ++++++
 rtl/dmem_access_ctrl_if.sv | 38 +++
 rtl/load_align_ext.sv | 33 +++
 rtl/dmem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
//   - RISC-V load/store funct3 encodings
//   - access-size field encodings (funct3[1:0])
//   - controller FSM state type
//   - helpers: funct3 legality, address alignment, store lane enables and lane data
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size is carried in funct3[1:0] for both loads and stores.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } state_e;

  // 011, 110 and 111 have no load/store meaning (110 would be LWU on RV64).
  function automatic logic f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      SZ_W:    ok = (off == 2'b00);
      SZ_H:    ok = ~off[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Loads always fetch the whole word; stores enable only the lanes they write.
  function automatic logic [3:0] lane_en(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [3:0] be;
    if (!is_store) begin
      be = 4'b1111;
    end else begin
      case (f3[1:0])
        SZ_B:    be = 4'b0001 << off;
        SZ_H:    be = 4'b0011 << {off[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Replicate the store operand across all lanes so the enables alone pick the target.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] wd;
    case (f3[1:0])
      SZ_B:    wd = {4{data[7:0]}};
      SZ_H:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and the external memory.
//   master (controller): drives mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en;
//                        samples mem_rdata, mem_ready
//   slave  (memory):     the reverse
// mem_ready is a one-cycle completion pulse; mem_rdata is valid only with it.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byte_en;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_byte_en,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_byte_en,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/load_align_ext.sv
// Load alignment and extension (purely combinational).
//   rdata_i  : full 32-bit word returned by memory
//   offset_i : byte offset of the access within the word (Address[1:0])
//   funct3_i : load funct3 (LB/LH/LW/LBU/LHU)
//   result_o : selected byte/half/word, sign- or zero-extended to 32 bits
// Encodings without a load meaning yield zero.
module load_align_ext
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = '0;
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    result_o = rdata_i;
      F3_BU:   result_o = {24'h0, byte_sel};
      F3_HU:   result_o = {16'h0, half_sel};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller for an RV32IM pipeline.
// Issues one registered request per legal load/store held in EX/MEM, stalls the upstream
// pipeline until the memory answers (or a timeout fires), and hands the extended load
// result to MEM/WB.
//   CLK, Reset        : clock (rising edge), asynchronous active-high reset
//   Mem_Read/Write    : EX/MEM load/store flags (store wins when both are set)
//   Funct3, Address   : access type and byte address from EX/MEM
//   Store_Data        : rs2 value for stores
//   mem_bus           : memory request/ready bus (master side)
//   Stall             : freeze PC, IF/ID, ID/EX, EX/MEM
//   MemWB_Enable      : MEM/WB may capture this cycle
//   Load_Data         : extended load result
//   Access_Exception  : misaligned address or illegal funct3 (no request issued)
//   Bus_Error         : memory did not answer within TIMEOUT_CYCLES
//   Kill_Writeback    : suppress the register write of the entry MEM/WB captures now
module dmem_access_ctrl
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_W-1:0]     Address,
  input  logic [31:0]           Store_Data,
  dmem_access_ctrl_if.master    mem_bus,
  output logic                  Stall,
  output logic                  MemWB_Enable,
  output logic [31:0]           Load_Data,
  output logic                  Access_Exception,
  output logic                  Bus_Error,
  output logic                  Kill_Writeback
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       ld_q, ld_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              load_q, load_d;
  logic              tout_q, tout_d;

  logic              pending;
  logic              is_store;
  logic              legal;
  logic [31:0]       ext_data;

  // Reset masks the request decode so Stall drops asynchronously even while the
  // EX/MEM register still holds a memory instruction.
  assign pending  = ~Reset & (Mem_Read | Mem_Write);
  assign is_store = Mem_Write;
  assign legal    = f3_legal(Funct3) & addr_aligned(Funct3, Address[1:0]);

  // Offset and funct3 are the copies latched at request time, not the live EX/MEM fields.
  load_align_ext u_load_align_ext (
    .rdata_i  (mem_bus.mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (ext_data)
  );

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    ld_d             = ld_q;
    cnt_d            = cnt_q;
    off_d            = off_q;
    f3_d             = f3_q;
    load_d           = load_q;
    tout_d           = tout_q;
    Stall            = 1'b0;
    MemWB_Enable     = 1'b1;
    Access_Exception = 1'b0;
    Bus_Error        = 1'b0;
    Kill_Writeback   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending) begin
          if (legal) begin
            Stall        = 1'b1;
            MemWB_Enable = 1'b0;
            state_d      = StAccess;
            req_d        = 1'b1;
            we_d         = is_store;
            addr_d       = {Address[ADDR_W-1:2], 2'b00};
            wdata_d      = is_store ? lane_data(Funct3, Store_Data) : '0;
            be_d         = lane_en(is_store, Funct3, Address[1:0]);
            off_d        = Address[1:0];
            f3_d         = Funct3;
            load_d       = ~is_store;
            cnt_d        = '0;
            tout_d       = 1'b0;
          end else begin
            // Faulting access never reaches memory; the pipeline keeps flowing.
            Access_Exception = 1'b1;
            Kill_Writeback   = 1'b1;
          end
        end
      end

      StAccess: begin
        Stall        = 1'b1;
        MemWB_Enable = 1'b0;
        cnt_d        = cnt_q + 8'd1;
        // Ready takes priority, so a reply on the final cycle still succeeds.
        if (mem_bus.mem_ready) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = load_q ? ext_data : '0;
          tout_d  = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = '0;
          tout_d  = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        Bus_Error      = tout_q;
        Kill_Writeback = tout_q;
        tout_d         = 1'b0;
        cnt_d          = '0;
        state_d        = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ld_q    <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      load_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      tout_q  <= tout_d;
    end
  end

  assign mem_bus.mem_req     = req_q;
  assign mem_bus.mem_we      = we_q;
  assign mem_bus.mem_addr    = addr_q;
  assign mem_bus.mem_wdata   = wdata_q;
  assign mem_bus.mem_byte_en = be_q;
  assign Load_Data           = ld_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios followed by randomized
// loads/stores, each checked against an arithmetic reference model of the access rules.
module tb_dmem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        CLK;
  logic        Reset;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [2:0]  Funct3;
  logic [31:0] Address;
  logic [31:0] Store_Data;
  logic        Stall;
  logic        MemWB_Enable;
  logic [31:0] Load_Data;
  logic        Access_Exception;
  logic        Bus_Error;
  logic        Kill_Writeback;

  int tests = 0;
  int fails = 0;

  dmem_access_ctrl_if #(.ADDR_W(32)) bus ();

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .ADDR_W         (32)
  ) dut (
    .CLK              (CLK),
    .Reset            (Reset),
    .Mem_Read         (Mem_Read),
    .Mem_Write        (Mem_Write),
    .Funct3           (Funct3),
    .Address          (Address),
    .Store_Data       (Store_Data),
    .mem_bus          (bus),
    .Stall            (Stall),
    .MemWB_Enable     (MemWB_Enable),
    .Load_Data        (Load_Data),
    .Access_Exception (Access_Exception),
    .Bus_Error        (Bus_Error),
    .Kill_Writeback   (Kill_Writeback)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", fails);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the access should look like, from the size/alignment rules.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, output bit pend, output bit st,
                                output bit lgl, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int     size;
    int     off;
    longint v;
    longint span;
    pend = (rd | wr);
    st   = wr;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(addr % 4);
    lgl  = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && (off % size == 0);
    be   = st ? 4'(((1 << size) - 1) << off) : 4'hF;
    wd   = (size == 1) ? sdata[7:0] * 32'h0101_0101 :
           (size == 2) ? sdata[15:0] * 32'h0001_0001 : sdata;
    span = longint'(1) << (8 * size);
    v    = longint'(rdata >> (off * 8)) % span;
    if (f3[2] == 1'b0 && size < 4 && v >= span / 2) v = v - span;
    ld   = 32'(v);
  endfunction

  // Present one EX/MEM instruction (called at posedge+1), act as memory answering after
  // wait_n ACCESS cycles, and follow it until MEM/WB captures.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int wait_n);
    bit          pend, st, lgl, berr, exc;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    int          e_stall, e_req;
    int          stall_n, req_n, exc_n, berr_n, kill_n, en_bad;
    bit          done;
    logic        cap_en;
    logic [31:0] cap_ld;

    model(rd, wr, f3, addr, sdata, rdata, pend, st, lgl, e_be, e_wd, e_ld);
    exc     = pend && !lgl;
    berr    = pend && lgl && (wait_n >= int'(TO));
    e_req   = (pend && lgl) ? (berr ? int'(TO) : wait_n + 1) : 0;
    e_stall = (pend && lgl) ? e_req + 1 : 0;
    stall_n = 0; req_n = 0; exc_n = 0; berr_n = 0; kill_n = 0; en_bad = 0;
    done    = 0;
    cap_en  = 1'b0;
    cap_ld  = '0;

    Mem_Read = rd; Mem_Write = wr; Funct3 = f3; Address = addr; Store_Data = sdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      // Outside ACCESS the memory line is noisy; the controller must ignore it.
      if (bus.mem_req) bus.mem_ready = (req_n == wait_n);
      else             bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = (bus.mem_req && bus.mem_ready) ? rdata : $urandom();
      @(negedge CLK);
      if (bus.mem_req) begin
        check($sformatf("%s/addr", tag), bus.mem_addr, {addr[31:2], 2'b00});
        check($sformatf("%s/we", tag), 32'(bus.mem_we), 32'(st));
        check($sformatf("%s/byte_en", tag), 32'(bus.mem_byte_en), 32'(e_be));
        if (st) check($sformatf("%s/wdata", tag), bus.mem_wdata, e_wd);
        req_n++;
      end
      if (Access_Exception) exc_n++;
      if (Bus_Error)        berr_n++;
      if (Kill_Writeback)   kill_n++;
      if (Stall) begin
        stall_n++;
        if (MemWB_Enable !== 1'b0) en_bad++;
      end else begin
        done   = 1;
        cap_en = MemWB_Enable;
        cap_ld = Load_Data;
      end
      @(posedge CLK);
      #1;
    end
    bus.mem_ready = 1'b0;

    check($sformatf("%s/completed", tag), 32'(done), 32'd1);
    check($sformatf("%s/stall_cycles", tag), 32'(stall_n), 32'(e_stall));
    check($sformatf("%s/req_cycles", tag), 32'(req_n), 32'(e_req));
    check($sformatf("%s/memwb_low_while_stalled", tag), 32'(en_bad), 32'd0);
    check($sformatf("%s/memwb_capture", tag), 32'(cap_en), 32'd1);
    check($sformatf("%s/access_exc_pulses", tag), 32'(exc_n), 32'(exc));
    check($sformatf("%s/bus_err_pulses", tag), 32'(berr_n), 32'(berr));
    check($sformatf("%s/kill_pulses", tag), 32'(kill_n), 32'(exc | berr));
    if (pend && lgl) begin
      check($sformatf("%s/load_data", tag), cap_ld, (st || berr) ? 32'h0 : e_ld);
    end
  endtask

  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic        r_rd, r_wr;
  int          r_kind;
  logic [2:0]  legal_f3 [5];

  initial begin
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    Reset = 1'b1;
    Mem_Read = 1'b0; Mem_Write = 1'b0; Funct3 = '0; Address = '0; Store_Data = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    repeat (2) @(negedge CLK);
    check("reset/mem_req", 32'(bus.mem_req), 32'd0);
    check("reset/mem_we", 32'(bus.mem_we), 32'd0);
    check("reset/mem_addr", bus.mem_addr, 32'd0);
    check("reset/mem_wdata", bus.mem_wdata, 32'd0);
    check("reset/mem_byte_en", 32'(bus.mem_byte_en), 32'd0);
    check("reset/load_data", Load_Data, 32'd0);
    check("reset/stall", 32'(Stall), 32'd0);
    check("reset/memwb_en", 32'(MemWB_Enable), 32'd1);
    check("reset/flags", {29'd0, Access_Exception, Bus_Error, Kill_Writeback}, 32'd0);
    Reset = 1'b0;
    @(posedge CLK);
    #1;

    // Reset while a request is outstanding.
    Mem_Read = 1'b1; Funct3 = 3'd2; Address = 32'h0000_5000;
    @(posedge CLK);
    #1;
    check("rst_mid/req_before", 32'(bus.mem_req), 32'd1);
    @(posedge CLK);
    #3;
    Reset = 1'b1;
    #1;
    check("rst_mid/req_async", 32'(bus.mem_req), 32'd0);
    check("rst_mid/stall_async", 32'(Stall), 32'd0);
    check("rst_mid/addr_async", bus.mem_addr, 32'd0);
    Mem_Read = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("rst_mid/memwb_after", 32'(MemWB_Enable), 32'd1);
    check("rst_mid/stall_after", 32'(Stall), 32'd0);
    @(posedge CLK);
    #1;
    check("rst_mid/idle_no_req", 32'(bus.mem_req), 32'd0);

    // Directed scenarios (rd, wr, f3, addr, store data, read data, wait cycles).
    run_op("lb_1003",    1, 0, 3'd0, 32'h0000_1003, 32'h0,         32'h80FF_1122, 0);
    run_op("sh_2002",    0, 1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0,         3);
    run_op("lw_misal",   1, 0, 3'd2, 32'h0000_3001, 32'h0,         32'h0,         0);
    run_op("f3_011",     1, 0, 3'd3, 32'h0000_3000, 32'h0,         32'h0,         0);
    run_op("sw_f3_110",  0, 1, 3'd6, 32'h0000_3000, 32'h1234_5678, 32'h0,         0);
    run_op("lhu_tmo",    1, 0, 3'd5, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF, 99);
    run_op("lh_edge",    1, 0, 3'd1, 32'h0000_4002, 32'h0,         32'h8001_7FFF, TO - 1);
    run_op("b2b_lw",     1, 0, 3'd2, 32'h0000_6004, 32'h0,         32'hCAFE_F00D, 1);
    run_op("b2b_sw",     0, 1, 3'd2, 32'h0000_6008, 32'hA5A5_5A5A, 32'h0,         0);
    run_op("b2b_nonmem", 0, 0, 3'd2, 32'h0000_600C, 32'h0,         32'h0,         0);
    run_op("rd_and_wr",  1, 1, 3'd0, 32'h0000_7001, 32'h0000_00C3, 32'h1111_1111, 2);
    run_op("lbu_1002",   1, 0, 3'd4, 32'h0000_1002, 32'h0,         32'h0080_0000, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      r_kind = int'($urandom_range(0, 9));
      r_rd   = (r_kind < 4) || (r_kind == 7);
      r_wr   = (r_kind >= 4) && (r_kind <= 7);
      r_f3   = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)]
                                          : 3'($urandom_range(0, 7));
      r_addr = $urandom();
      if ($urandom_range(0, 9) < 7) begin
        if (r_f3[1:0] == 2'd2)      r_addr[1:0] = 2'b00;
        else if (r_f3[1:0] == 2'd1) r_addr[0]   = 1'b0;
      end
      run_op($sformatf("rand%0d", i), r_rd, r_wr, r_f3, r_addr, $urandom(), $urandom(),
             int'($urandom_range(0, 5)));
    end

    Mem_Read = 1'b0; Mem_Write = 1'b0;
    @(negedge CLK);
    check("end/idle_stall", 32'(Stall), 32'd0);
    check("end/idle_req", 32'(bus.mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
